// File: rtl/mem_bus_responder.sv
// Word-addressed memory slave with per-direction wait states, gated by a CPU-launch handshake.
// Optional rd/wr transaction counters are enabled with `define MEM_BUS_RESPONDER_STATS_EN.
module mem_bus_responder #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter int                DEPTH   = 128,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter int                RD_WAIT = 1,
    parameter int                WR_WAIT = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read_q,
    input  logic              write_q,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              read_dn,
    output logic              write_dn,
    output logic              bus_busy,
    output logic              err,
    input  logic              launch_go,
    input  logic [DATA_W-1:0] launch_index,
    output logic              cpu_q,
    output logic [DATA_W-1:0] cpu_index,
    input  logic              cpu_e,
    output logic              running
`ifdef MEM_BUS_RESPONDER_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT, L_RUN} launch_state_t;
    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} bus_state_t;

    launch_state_t     l_state;
    bus_state_t        bus_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_wr;
    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic              served_low;
    logic              accept;
    logic              finishing;
    logic [DATA_W-1:0] mem [DEPTH];

    // off wraps modulo 2^ADDR_W, so addresses below BASE need the explicit >= test
    assign off        = lat_addr - BASE;
    assign in_range   = (lat_addr >= BASE) && (off < DEPTH_A);
    assign served_low = lat_wr ? !write_q : !read_q;
    assign accept     = running && (read_q || write_q) &&
                        ((bus_state == IDLE) || (bus_state == RELEASE && served_low));
    assign finishing  = (bus_state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            l_state   <= L_IDLE;
            cpu_q     <= 1'b0;
            cpu_index <= '0;
            running   <= 1'b0;
        end else begin
            case (l_state)
                L_IDLE: if (launch_go) begin
                    l_state   <= L_REQ;
                    cpu_q     <= 1'b1;
                    cpu_index <= launch_index;
                end
                L_REQ: begin
                    cpu_q     <= 1'b0;
                    cpu_index <= '0;
                    if (cpu_e) begin
                        l_state <= L_RUN;
                        running <= 1'b1;
                    end else begin
                        l_state <= L_WAIT;
                    end
                end
                L_WAIT: if (cpu_e) begin
                    l_state <= L_RUN;
                    running <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_wr    <= !read_q;
        end
    end

    // Write commit is suppressed by RESET so an aborted transaction leaves the array untouched
    always_ff @(posedge CLK) begin
        if (finishing && lat_wr && in_range && !RESET)
            mem[off[IDX_W-1:0]] <= lat_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus_state <= IDLE;
            cnt       <= 4'd0;
            rdata     <= '0;
            rdata_oe  <= 1'b0;
            read_dn   <= 1'b0;
            write_dn  <= 1'b0;
            bus_busy  <= 1'b0;
            err       <= 1'b0;
        end else begin
            rdata    <= '0;
            rdata_oe <= 1'b0;
            read_dn  <= 1'b0;
            write_dn <= 1'b0;
            err      <= 1'b0;
            case (bus_state)
                WAIT: begin
                    if (cnt == 4'd0) begin
                        bus_state <= DONE;
                        err       <= !in_range;
                        if (lat_wr) begin
                            write_dn <= 1'b1;
                        end else begin
                            read_dn  <= 1'b1;
                            rdata_oe <= 1'b1;
                            rdata    <= in_range ? mem[off[IDX_W-1:0]] : '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    bus_state <= RELEASE;
                    bus_busy  <= 1'b0;
                end
                default: begin
                    if (accept) begin
                        bus_state <= WAIT;
                        bus_busy  <= 1'b1;
                        cnt       <= read_q ? 4'(RD_WAIT) : 4'(WR_WAIT);
                    end else if (bus_state == IDLE || served_low) begin
                        bus_state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MEM_BUS_RESPONDER_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (finishing) begin
            if (lat_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (!lat_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized self-checking bench for mem_bus_responder against a word-array reference model.
module tb_mem_bus_responder;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 128;
    localparam logic [31:0] BASE  = 32'd16;
    localparam int          RDW   = 1;
    localparam int          WRW   = 0;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          read_q, write_q;
    logic [DW-1:0] rdata;
    logic          rdata_oe, read_dn, write_dn, bus_busy, err;
    logic          launch_go;
    logic [DW-1:0] launch_index;
    logic          cpu_q;
    logic [DW-1:0] cpu_index;
    logic          cpu_e;
    logic          running;
`ifdef MEM_BUS_RESPONDER_STATS_EN
    logic [15:0]   rd_count, wr_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    logic [DW-1:0] mem_m [DEPTH];

    always #5 CLK = ~CLK;

    mem_bus_responder #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE(BASE),
        .RD_WAIT(RDW), .WR_WAIT(WRW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .addr(addr), .wdata(wdata),
        .read_q(read_q), .write_q(write_q), .rdata(rdata), .rdata_oe(rdata_oe),
        .read_dn(read_dn), .write_dn(write_dn), .bus_busy(bus_busy), .err(err),
        .launch_go(launch_go), .launch_index(launch_index), .cpu_q(cpu_q),
        .cpu_index(cpu_index), .cpu_e(cpu_e), .running(running)
`ifdef MEM_BUS_RESPONDER_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint o = longint'(a) - longint'(BASE);
        return (o >= 0) && (o < DEPTH);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rdata_oe"}, rdata_oe, 0);
        chk({tag, "_read_dn"}, read_dn, 0);
        chk({tag, "_write_dn"}, write_dn, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic wait_pulse(input bit wr, output int n);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!(wr ? write_dn : read_dn) && n < 40);
        if (!(wr ? write_dn : read_dn)) chk("dn_timeout", 0, 1);
    endtask

    // One full transaction; request is raised now and dropped in the dn cycle
    task automatic bus_txn(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        bit ok = in_rng(a);
        logic [31:0] exp_rd = ok ? mem_m[a - BASE] : 32'd0;
        addr = a; wdata = d;
        if (wr) write_q = 1'b1; else read_q = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
            if (n == 1) chk("busy_after_accept", bus_busy, 1);
        end while (!(wr ? write_dn : read_dn) && n < 40);
        chk("dn_latency", n, 2 + (wr ? WRW : RDW));
        chk("dn_err", err, !ok);
        if (wr) begin
            chk("wr_no_read_dn", read_dn, 0);
            chk("wr_no_rdata_oe", rdata_oe, 0);
            if (ok) mem_m[a - BASE] = d;
            wr_pulses++;
        end else begin
            chk("rd_oe", rdata_oe, 1);
            chk("rd_data", rdata, exp_rd);
            rd_pulses++;
        end
        write_q = 1'b0; read_q = 1'b0;
        @(posedge CLK); #1;
        check_idle_outputs("after_dn");
        @(posedge CLK); #1;
    endtask

    task automatic launch(input logic [31:0] idx);
        launch_go = 1'b1; launch_index = idx;
        @(posedge CLK); #1;
        launch_go = 1'b0;
        chk("cpu_q_pulse", cpu_q, 1);
        chk("cpu_index", cpu_index, idx);
        chk("pending_rd_unserved", read_dn, 0);
        @(posedge CLK); #1;
        chk("cpu_q_single", cpu_q, 0);
        chk("cpu_index_zero", cpu_index, 0);
        @(posedge CLK); #1;
        chk("not_running_yet", running, 0);
        chk("pending_rd_unserved2", read_dn, 0);
        cpu_e = 1'b1;
        @(posedge CLK); #1;
        cpu_e = 1'b0;
        chk("running", running, 1);
    endtask

    initial begin
        int n;
        logic [31:0] a, d, old;
        RESET = 1'b1; addr = '0; wdata = '0; read_q = 0; write_q = 0;
        launch_go = 0; launch_index = '0; cpu_e = 0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_idle_outputs("reset");
        chk("reset_busy", bus_busy, 0);
        chk("reset_cpu_q", cpu_q, 0);
        chk("reset_cpu_index", cpu_index, 0);
        chk("reset_running", running, 0);

        // Read below BASE issued before launch: held pending, then served out of range
        addr = 32'd3; read_q = 1'b1;
        repeat (4) begin
            @(posedge CLK); #1;
            chk("prelaunch_no_dn", read_dn, 0);
            chk("prelaunch_not_busy", bus_busy, 0);
        end
        launch(32'd18);
        bus_txn(0, 32'd3, 32'd0);

        launch_go = 1'b1;
        @(posedge CLK); #1;
        launch_go = 1'b0;
        chk("launch_ignored", cpu_q, 0);

        for (int i = 0; i < DEPTH; i++) bus_txn(1, BASE + i, $urandom);
        bus_txn(1, BASE + 5, 32'hDEADBEEF);
        bus_txn(0, BASE + 5, 32'd0);
        bus_txn(1, BASE + 7, 32'h12345678);
        bus_txn(0, BASE + 7, 32'd0);

        // Simultaneous read and write on one address: read first with old data
        a = BASE + 20; d = $urandom; old = mem_m[20];
        addr = a; wdata = d; read_q = 1'b1; write_q = 1'b1;
        wait_pulse(0, n);
        chk("simul_rd_first", rdata, old);
        chk("simul_no_wr_dn", write_dn, 0);
        rd_pulses++;
        read_q = 1'b0;
        wait_pulse(1, n);
        chk("simul_wr_err", err, 0);
        wr_pulses++;
        mem_m[20] = d;
        write_q = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        bus_txn(0, a, 32'd0);

        bus_txn(1, BASE + DEPTH, 32'hA5A5A5A5);
        bus_txn(1, 32'hFFFF_FFFF, 32'h5A5A5A5A);
        for (int i = 0; i < DEPTH; i++) bus_txn(0, BASE + i, 32'd0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: a = $urandom_range(0, BASE - 1);
                1: a = BASE + DEPTH + $urandom_range(0, 1000);
                default: a = BASE + $urandom_range(0, DEPTH - 1);
            endcase
            bus_txn($urandom_range(0, 1), a, $urandom);
        end

`ifdef MEM_BUS_RESPONDER_STATS_EN
        chk("rd_count", rd_count, rd_pulses);
        chk("wr_count", wr_count, wr_pulses);
`endif

        // Reset during WAIT of a write aborts it without committing
        addr = BASE + 9; wdata = ~mem_m[9]; write_q = 1'b1;
        @(posedge CLK); #1;
        chk("abort_busy", bus_busy, 1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_idle_outputs("abort");
        chk("abort_busy_clr", bus_busy, 0);
        chk("abort_running", running, 0);
        chk("abort_cpu_q", cpu_q, 0);
        RESET = 1'b0; write_q = 1'b0;
        rd_pulses = 0; wr_pulses = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("abort_no_wr_dn", write_dn, 0);
        end
        launch($urandom);
        bus_txn(0, BASE + 9, 32'd0);
`ifdef MEM_BUS_RESPONDER_STATS_EN
        chk("rd_count_after_reset", rd_count, rd_pulses);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
